// File: rtl/comp_sync_gen_if.sv
// Composite sync generator signal bundle: system select in, timing flags and
// pixel counters out. The master side is the generator, the slave side is
// the downstream consumer (chroma generator / encoder).
interface comp_sync_gen_if;
    logic       cs_pnsel;
    logic       cs_mode;
    logic       cs_hsync;
    logic       cs_csync;
    logic       cs_blank;
    logic       cs_enable;
    logic       cs_frame;
    logic [9:0] cs_hcnt;
    logic [8:0] cs_vcnt;

    modport master (
        input  cs_pnsel,
        output cs_mode, cs_hsync, cs_csync, cs_blank, cs_enable, cs_frame,
        output cs_hcnt, cs_vcnt
    );

    modport slave (
        output cs_pnsel,
        input  cs_mode, cs_hsync, cs_csync, cs_blank, cs_enable, cs_frame,
        input  cs_hcnt, cs_vcnt
    );
endinterface

// File: rtl/comp_sync_gen.sv
// Composite video timing generator (PAL/NTSC, progressive frames).
// A free-running (h,v) position is decoded into sync/blank flags; every
// output is registered from the same (h,v), so flags and counters align.
// The system select is latched only at the frame origin so a frame never
// mixes line lengths.
module comp_sync_gen #(
    parameter int H_PAL       = 896,
    parameter int H_NTSC      = 889,
    parameter int HSYNC_LEN   = 66,
    parameter int EQ_LEN      = 33,
    parameter int H_ACT_START = 150,
    parameter int H_ACT_END   = 870,
    parameter int V_ACT_START = 16
) (
    input  logic             cs_clock,
    input  logic             cs_rst_n,
    comp_sync_gen_if.master  bus
);

    localparam logic [1:0] LINE_NORMAL = 2'd0;
    localparam logic [1:0] LINE_EQ     = 2'd1;
    localparam logic [1:0] LINE_BROAD  = 2'd2;

    localparam logic [9:0] HT_PAL     = 10'(H_PAL);
    localparam logic [9:0] HT_NTSC    = 10'(H_NTSC);
    localparam logic [9:0] HL_PAL     = 10'(H_PAL / 2);
    localparam logic [9:0] HL_NTSC    = 10'(H_NTSC / 2);
    localparam logic [9:0] HS_LEN     = 10'(HSYNC_LEN);
    localparam logic [9:0] EQ_W       = 10'(EQ_LEN);
    localparam logic [9:0] ACT_START  = 10'(H_ACT_START);
    localparam logic [9:0] ACT_E_PAL  = 10'(H_ACT_END);
    // NTSC lines are shorter, so active video must end earlier
    localparam logic [9:0] ACT_E_NTSC = 10'((H_ACT_END > H_NTSC - 19) ? (H_NTSC - 19) : H_ACT_END);
    localparam logic [8:0] VT_PAL     = 9'd312;
    localparam logic [8:0] VT_NTSC    = 9'd262;
    localparam logic [8:0] V_ACT      = 9'(V_ACT_START);

    logic [9:0] h_r;
    logic [8:0] v_r;
    logic       mode_r;
    logic       hsync_r, csync_r, blank_r, enable_r, frame_r;
    logic [9:0] hcnt_r;
    logic [8:0] vcnt_r;

    logic       at_origin_s, mode_eff_s;
    logic [9:0] ht_s, hl_s, act_end_s;
    logic [8:0] vt_s;
    logic [1:0] line_type_s;
    logic       hsync_low_s, csync_low_s, blank_s;
    logic [9:0] h_nxt_s;
    logic [8:0] v_nxt_s;

    // Select per-mode geometry; at the origin the incoming select already governs the new frame
    always_comb begin
        at_origin_s = (h_r == 10'd0) && (v_r == 9'd0);
        if (at_origin_s) begin
            mode_eff_s = bus.cs_pnsel;
        end else begin
            mode_eff_s = mode_r;
        end
        if (mode_eff_s) begin
            ht_s      = HT_NTSC;
            hl_s      = HL_NTSC;
            act_end_s = ACT_E_NTSC;
            vt_s      = VT_NTSC;
        end else begin
            ht_s      = HT_PAL;
            hl_s      = HL_PAL;
            act_end_s = ACT_E_PAL;
            vt_s      = VT_PAL;
        end
    end

    // Classify the current line and decode the sync/blank flags from (h,v)
    always_comb begin
        case (v_r)
            9'd0, 9'd1, 9'd2, 9'd6, 9'd7, 9'd8: line_type_s = LINE_EQ;
            9'd3, 9'd4, 9'd5:                   line_type_s = LINE_BROAD;
            default:                            line_type_s = LINE_NORMAL;
        endcase
        hsync_low_s = (h_r < HS_LEN);
        case (line_type_s)
            LINE_EQ:    csync_low_s = (h_r < EQ_W) ||
                                      ((h_r >= hl_s) && (h_r < hl_s + EQ_W));
            LINE_BROAD: csync_low_s = (h_r < hl_s - HS_LEN) ||
                                      ((h_r >= hl_s) && (h_r < ht_s - HS_LEN));
            default:    csync_low_s = hsync_low_s;
        endcase
        blank_s = (h_r < ACT_START) || (h_r >= act_end_s) || (v_r < V_ACT);
    end

    // Next raster position: wrap h at end of line, wrap v at end of frame
    always_comb begin
        if (h_r == ht_s - 10'd1) begin
            h_nxt_s = 10'd0;
            if (v_r == vt_s - 9'd1) begin
                v_nxt_s = 9'd0;
            end else begin
                v_nxt_s = v_r + 9'd1;
            end
        end else begin
            h_nxt_s = h_r + 10'd1;
            v_nxt_s = v_r;
        end
    end

    // Raster counters and frame-locked system select
    always_ff @(posedge cs_clock or negedge cs_rst_n) begin
        if (!cs_rst_n) begin
            h_r    <= 10'd0;
            v_r    <= 9'd0;
            mode_r <= 1'b0;
        end else begin
            h_r    <= h_nxt_s;
            v_r    <= v_nxt_s;
            mode_r <= mode_eff_s;
        end
    end

    // Output registers: flags and counter copies all taken from the same (h,v)
    always_ff @(posedge cs_clock or negedge cs_rst_n) begin
        if (!cs_rst_n) begin
            hsync_r  <= 1'b1;
            csync_r  <= 1'b1;
            blank_r  <= 1'b1;
            enable_r <= 1'b0;
            frame_r  <= 1'b0;
            hcnt_r   <= 10'd0;
            vcnt_r   <= 9'd0;
        end else begin
            hsync_r  <= ~hsync_low_s;
            csync_r  <= ~csync_low_s;
            blank_r  <= blank_s;
            enable_r <= ~blank_s;
            frame_r  <= at_origin_s;
            hcnt_r   <= h_r;
            vcnt_r   <= v_r;
        end
    end

    assign bus.cs_mode   = mode_r;
    assign bus.cs_hsync  = hsync_r;
    assign bus.cs_csync  = csync_r;
    assign bus.cs_blank  = blank_r;
    assign bus.cs_enable = enable_r;
    assign bus.cs_frame  = frame_r;
    assign bus.cs_hcnt   = hcnt_r;
    assign bus.cs_vcnt   = vcnt_r;

endmodule

// File: tb/tb_comp_sync_gen.sv
// Bench for comp_sync_gen: a shrunken-line instance runs whole frames, a
// default-geometry instance shares clock/reset/select and is checked over
// the first lines of each frame. The reference model tracks the position
// inside the frame as a single cycle index and derives (h,v) arithmetically.
module tb_comp_sync_gen;

    localparam int SP = 64, SN = 59, SHS = 5, SEQ = 3, SAS = 10, SAE = 58, VAS = 16;
    localparam int DP = 896, DN = 889, DHS = 66, DEQ = 33, DAS = 150, DAE = 870;
    // {mode, hsync, csync, blank, enable, frame, hcnt[9:0], vcnt[8:0]}
    localparam logic [24:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 9'd0};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pnsel = 1'b0;

    int checks = 0;
    int errors = 0;

    int          t_s = 0, t_d = 0;
    bit          m_s = 1'b0, m_d = 1'b0;
    logic [24:0] exp_s = RST_VEC, exp_d = RST_VEC;

    comp_sync_gen_if s_if ();
    comp_sync_gen_if d_if ();

    assign s_if.cs_pnsel = pnsel;
    assign d_if.cs_pnsel = pnsel;

    comp_sync_gen #(
        .H_PAL(SP), .H_NTSC(SN), .HSYNC_LEN(SHS), .EQ_LEN(SEQ),
        .H_ACT_START(SAS), .H_ACT_END(SAE), .V_ACT_START(VAS)
    ) dut_s (
        .cs_clock (clk),
        .cs_rst_n (rst_n),
        .bus      (s_if)
    );

    comp_sync_gen dut_d (
        .cs_clock (clk),
        .cs_rst_n (rst_n),
        .bus      (d_if)
    );

    wire [24:0] obs_s = {s_if.cs_mode, s_if.cs_hsync, s_if.cs_csync, s_if.cs_blank,
                         s_if.cs_enable, s_if.cs_frame, s_if.cs_hcnt, s_if.cs_vcnt};
    wire [24:0] obs_d = {d_if.cs_mode, d_if.cs_hsync, d_if.cs_csync, d_if.cs_blank,
                         d_if.cs_enable, d_if.cs_frame, d_if.cs_hcnt, d_if.cs_vcnt};

    always #5 clk = ~clk;

    function automatic int flen(input int hpal, input int hntsc, input bit m);
        return m ? hntsc * 262 : hpal * 312;
    endfunction

    // Expected outputs for frame cycle index t under mode m
    function automatic logic [24:0] ref_out(input int hpal, input int hntsc, input int hs,
                                            input int eq, input int as, input int ae,
                                            input int t, input bit m);
        int ht, h, v, hl, aend;
        bit low, blank;
        ht   = m ? hntsc : hpal;
        h    = t % ht;
        v    = t / ht;
        hl   = ht / 2;
        aend = ae;
        if (m && aend > hntsc - 19) aend = hntsc - 19;
        if (v <= 2 || (v >= 6 && v <= 8))
            low = (h < eq) || (h >= hl && h < hl + eq);
        else if (v >= 3 && v <= 5)
            low = (h < hl - hs) || (h >= hl && h < ht - hs);
        else
            low = (h < hs);
        blank = (h < as) || (h >= aend) || (v < VAS);
        return {m, !(h < hs), !low, blank, !blank, (t == 0), 10'(h), 9'(v)};
    endfunction

    // One clock: advance both models at the rising edge, then settle past it
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (t_s == 0) m_s = pnsel;
            exp_s = ref_out(SP, SN, SHS, SEQ, SAS, SAE, t_s, m_s);
            t_s   = (t_s + 1) % flen(SP, SN, m_s);
            if (t_d == 0) m_d = pnsel;
            exp_d = ref_out(DP, DN, DHS, DEQ, DAS, DAE, t_d, m_d);
            t_d   = (t_d + 1) % flen(DP, DN, m_d);
        end else begin
            exp_s = RST_VEC; t_s = 0; m_s = 1'b0;
            exp_d = RST_VEC; t_d = 0; m_d = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pnsel = 1'($urandom_range(0, 1));
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_s !== RST_VEC) begin errors++; $display("FAIL reset_s got=%h want=%h", obs_s, RST_VEC); end
            checks++;
            if (obs_d !== RST_VEC) begin errors++; $display("FAIL reset_d got=%h want=%h", obs_d, RST_VEC); end
        end
        @(negedge clk);
        pnsel = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs_s[19] !== 1'b1) begin errors++; $display("FAIL first_frame got=%b want=1", obs_s[19]); end
        checks++;
        if (obs_s !== exp_s) begin errors++; $display("FAIL release_s got=%h want=%h", obs_s, exp_s); end
        tick();
        checks++;
        if (obs_s[19] !== 1'b0) begin errors++; $display("FAIL frame_width got=%b want=0", obs_s[19]); end
    endtask

    task automatic test_pal_frame();
        int n, en_cnt;
        n = 1;
        en_cnt = 0;
        while (n < 40000) begin
            tick();
            n++;
            checks++;
            if (obs_s !== exp_s) begin errors++; $display("FAIL pal_s t=%0d got=%h want=%h", t_s, obs_s, exp_s); end
            checks++;
            if (obs_d !== exp_d) begin errors++; $display("FAIL pal_d t=%0d got=%h want=%h", t_d, obs_d, exp_d); end
            if (obs_s[19]) break;
            if (obs_s[20]) en_cnt++;
        end
        checks++;
        if (n != SP * 312) begin errors++; $display("FAIL pal_period got=%0d want=%0d", n, SP * 312); end
        checks++;
        if (en_cnt != (312 - VAS) * (SAE - SAS)) begin
            errors++; $display("FAIL pal_enable_count got=%0d want=%0d", en_cnt, (312 - VAS) * (SAE - SAS));
        end
    endtask

    task automatic test_mode_switch();
        int n, falls;
        logic prev_hs;
        n = 0;
        while (n < 40000) begin
            if (n == SP * 100) begin
                @(negedge clk);
                pnsel = 1'b1;
            end
            tick();
            n++;
            checks++;
            if (obs_s !== exp_s) begin errors++; $display("FAIL switch_s t=%0d got=%h want=%h", t_s, obs_s, exp_s); end
            checks++;
            if (obs_d !== exp_d) begin errors++; $display("FAIL switch_d t=%0d got=%h want=%h", t_d, obs_d, exp_d); end
            if (obs_s[19]) break;
        end
        checks++;
        if (n != SP * 312) begin errors++; $display("FAIL switch_old_period got=%0d want=%0d", n, SP * 312); end
        checks++;
        if (obs_s[24] !== 1'b1) begin errors++; $display("FAIL switch_mode got=%b want=1", obs_s[24]); end
        // NTSC frame with random mid-frame select chatter that must be ignored
        n = 0;
        falls = 0;
        prev_hs = obs_s[23];
        while (n < 40000) begin
            if ($urandom_range(0, 499) == 0) begin
                @(negedge clk);
                pnsel = ~pnsel;
            end
            tick();
            n++;
            checks++;
            if (obs_s !== exp_s) begin errors++; $display("FAIL ntsc_s t=%0d got=%h want=%h", t_s, obs_s, exp_s); end
            checks++;
            if (obs_d !== exp_d) begin errors++; $display("FAIL ntsc_d t=%0d got=%h want=%h", t_d, obs_d, exp_d); end
            if (prev_hs && !obs_s[23]) falls++;
            prev_hs = obs_s[23];
            if (obs_s[19]) break;
        end
        checks++;
        if (n != SN * 262) begin errors++; $display("FAIL ntsc_period got=%0d want=%0d", n, SN * 262); end
        checks++;
        if (falls != 262) begin errors++; $display("FAIL ntsc_hsync_count got=%0d want=262", falls); end
    endtask

    task automatic test_reset_mid();
        int n, wait_n;
        wait_n = int'($urandom_range(200, 800));
        for (int i = 0; i < wait_n; i++) begin
            tick();
            checks++;
            if (obs_s !== exp_s) begin errors++; $display("FAIL pre_rst_s t=%0d got=%h want=%h", t_s, obs_s, exp_s); end
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_s !== RST_VEC) begin errors++; $display("FAIL async_rst_s got=%h want=%h", obs_s, RST_VEC); end
        checks++;
        if (obs_d !== RST_VEC) begin errors++; $display("FAIL async_rst_d got=%h want=%h", obs_d, RST_VEC); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_s !== RST_VEC) begin errors++; $display("FAIL hold_rst_s got=%h want=%h", obs_s, RST_VEC); end
        end
        @(negedge clk);
        pnsel = 1'b1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs_s[19] !== 1'b1) begin errors++; $display("FAIL rst_frame got=%b want=1", obs_s[19]); end
        n = 0;
        while (n < 40000) begin
            tick();
            n++;
            checks++;
            if (obs_s !== exp_s) begin errors++; $display("FAIL post_rst_s t=%0d got=%h want=%h", t_s, obs_s, exp_s); end
            checks++;
            if (obs_d !== exp_d) begin errors++; $display("FAIL post_rst_d t=%0d got=%h want=%h", t_d, obs_d, exp_d); end
            if (obs_s[19]) break;
        end
        checks++;
        if (n != SN * 262) begin errors++; $display("FAIL post_rst_period got=%0d want=%0d", n, SN * 262); end
    endtask

    initial begin
        test_reset();
        test_pal_frame();
        test_mode_switch();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
